// File: rtl/fft8_bitrev_buffer.sv
// Input reorder stage for the 8-point FFT: natural-order complex samples in,
// bit-reversed frames out. Two ping-pong banks let one frame load while the
// previous frame drains. Data words are stored and returned bit-exact.
module fft8_bitrev_buffer #(
  parameter int DATA_W   = 32,
  parameter int N_POINTS = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [DATA_W-1:0] i_data_re,
  input  logic [DATA_W-1:0] i_data_im,
  input  logic              i_last,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [DATA_W-1:0] o_data_re,
  output logic [DATA_W-1:0] o_data_im,
  output logic [2:0]        o_index,
  output logic              o_last,
  output logic              o_frame_err
);

  localparam int         ENTRY_W   = 2 * DATA_W;
  localparam logic [2:0] LAST_SLOT = 3'(N_POINTS - 1);

  logic [ENTRY_W-1:0] bank0 [8];
  logic [ENTRY_W-1:0] bank1 [8];
  logic [1:0]         full;
  logic               wr_bank;
  logic               rd_bank;
  logic [2:0]         wr_cnt;
  logic [2:0]         rd_cnt;

  logic               in_xfer;
  logic               out_xfer;
  logic               wr_done;
  logic               rd_done;
  logic [2:0]         wr_addr;
  logic [ENTRY_W-1:0] rd_entry;

  // Handshake qualifiers and the bit-reversed write address
  assign in_xfer  = i_valid && o_ready;
  assign out_xfer = o_valid && i_ready;
  assign wr_done  = in_xfer && (wr_cnt == LAST_SLOT);
  assign rd_done  = out_xfer && (rd_cnt == LAST_SLOT);
  assign wr_addr  = {wr_cnt[0], wr_cnt[1], wr_cnt[2]};

  // Ready looks only at the registered flag: a bank freed this cycle is
  // offered to the producer one cycle later.
  assign o_ready  = !i_rst && !full[wr_bank];

  // Read side is a plain mux of the draining bank
  assign rd_entry  = rd_bank ? bank1[rd_cnt] : bank0[rd_cnt];
  assign o_valid   = full[rd_bank];
  assign o_data_re = rd_entry[ENTRY_W-1:DATA_W];
  assign o_data_im = rd_entry[DATA_W-1:0];
  assign o_index   = rd_cnt;
  assign o_last    = o_valid && (rd_cnt == LAST_SLOT);

  // Sample storage; a write lands at the bit-reversed slot of its input index
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < 8; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
    end else if (in_xfer) begin
      if (wr_bank) bank1[wr_addr] <= {i_data_re, i_data_im};
      else         bank0[wr_addr] <= {i_data_re, i_data_im};
    end
  end

  // Write pointer: counts input transfers, hands the bank over after slot 7
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (in_xfer) begin
      wr_cnt <= wr_cnt + 3'd1;
      if (wr_done) wr_bank <= ~wr_bank;
    end
  end

  // Read pointer: counts output transfers, moves to the other bank after slot 7
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
    end else if (out_xfer) begin
      rd_cnt <= rd_cnt + 3'd1;
      if (rd_done) rd_bank <= ~rd_bank;
    end
  end

  // Bank-full flags; a write can never complete into the bank being drained,
  // so a set and a clear in the same cycle always target different bits.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      full <= '0;
    end else begin
      if (wr_done) full[wr_bank] <= 1'b1;
      if (rd_done) full[rd_bank] <= 1'b0;
    end
  end

  // Framing monitor: i_last must coincide exactly with the 8th transfer
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_frame_err <= 1'b0;
    end else begin
      o_frame_err <= in_xfer && (i_last != (wr_cnt == LAST_SLOT));
    end
  end

endmodule

// File: tb/tb_fft8_bitrev_buffer.sv
// Bench for fft8_bitrev_buffer: directed steps plus a random phase, all checked
// against a frame-level scoreboard that reorders each completed input frame.
module tb_fft8_bitrev_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vin = 1'b0;
  logic        rdy_in = 1'b0;
  logic        last_in = 1'b0;
  logic [31:0] dre = '0;
  logic [31:0] dim = '0;
  logic        o_ready, o_valid, o_last, o_frame_err;
  logic [31:0] o_data_re, o_data_im;
  logic [2:0]  o_index;

  always #5 clk = ~clk;

  fft8_bitrev_buffer #(.DATA_W(32), .N_POINTS(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(vin), .o_ready(o_ready),
    .i_data_re(dre), .i_data_im(dim), .i_last(last_in),
    .o_valid(o_valid), .i_ready(rdy_in), .o_data_re(o_data_re),
    .o_data_im(o_data_im), .o_index(o_index), .o_last(o_last),
    .o_frame_err(o_frame_err)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [2:0]  idx;
  } exp_t;

  int n_assert = 0;
  int n_fail   = 0;

  exp_t        exp_q[$];
  logic [31:0] out_log[$];
  logic [63:0] cur [8];
  int          pos = 0;
  logic        exp_err = 1'b0;
  bit          err_known = 0;
  bit          hold_pend = 0;
  logic [63:0] held_data;
  logic [2:0]  held_idx;
  logic        held_last;
  int          n_in = 0, n_out = 0, n_errp = 0, cyc = 0;

  logic        s_valid, s_ready, s_last, s_inx, s_outx;
  logic [2:0]  s_idx;
  logic [31:0] s_re, s_im;

  logic [31:0] fp [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                          32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
  logic [31:0] exp_order [8] = '{32'h3F800000, 32'h40A00000, 32'h40400000, 32'h40E00000,
                                 32'h40000000, 32'h40C00000, 32'h40800000, 32'h41000000};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int brev(input int n);
    return ((n & 1) << 2) | (n & 2) | ((n >> 2) & 1);
  endfunction

  // One clock: drive at negedge, sample 1ns later, update scoreboard, wait posedge
  task automatic tick(input logic v, input logic [31:0] re, input logic [31:0] im,
                      input logic l, input logic r, input logic r_rst);
    exp_t e;
    @(negedge clk);
    rst = r_rst; vin = v; dre = re; dim = im; last_in = l; rdy_in = r;
    #1;
    s_valid = o_valid; s_ready = o_ready; s_idx = o_index; s_last = o_last;
    s_re = o_data_re; s_im = o_data_im;
    s_inx = v && o_ready;
    s_outx = o_valid && r;
    if (err_known) chk("frame_err", o_frame_err, exp_err);
    if (o_frame_err === 1'b1) n_errp++;
    if (hold_pend) begin
      chk("hold_data", {o_data_re, o_data_im}, held_data);
      chk("hold_index", o_index, held_idx);
      chk("hold_last", o_last, held_last);
    end
    if (r_rst) begin
      exp_q.delete();
      pos = 0; exp_err = 1'b0; err_known = 1; hold_pend = 0;
      s_inx = 0; s_outx = 0;
    end else begin
      if (s_outx) begin
        n_out++;
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_data", {o_data_re, o_data_im}, e.data);
          chk("out_index", o_index, e.idx);
          chk("out_last", o_last, e.idx == 3'd7);
        end
        out_log.push_back(o_data_re);
      end
      if (s_inx) begin
        exp_err = (l != (pos == 7));
        cur[pos] = {re, im};
        pos++; n_in++;
        if (pos == 8) begin
          for (int k = 0; k < 8; k++) begin
            e.data = cur[brev(k)];
            e.idx  = 3'(k);
            exp_q.push_back(e);
          end
          pos = 0;
        end
      end else begin
        exp_err = 1'b0;
      end
      hold_pend = o_valid && !r;
      held_data = {o_data_re, o_data_im};
      held_idx  = o_index;
      held_last = o_last;
    end
    cyc++;
    @(posedge clk);
  endtask

  task automatic drain(input int target, input int bound);
    int b = bound;
    while (n_out < target && b > 0) begin
      tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      b--;
    end
    chk("drain_count", n_out, target);
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_log_size"}, out_log.size(), 8);
    for (int i = 0; i < 8 && i < out_log.size(); i++) chk(tag, out_log[i], exp_order[i]);
  endtask

  task automatic send_fp_frame(input int last_at, input logic r);
    for (int i = 0; i < 8; i++) tick(1'b1, fp[i], '0, i == last_at, r, 1'b0);
  endtask

  initial begin
    int base, first_c, last_c, errp0, acc0, b;
    logic [31:0] f_re, f_im;

    // Reset state
    tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    chk("rst_ready", s_ready, 0);
    chk("rst_valid", s_valid, 0);
    chk("rst_index", s_idx, 0);
    chk("rst_last", s_last, 0);
    chk("rst_data", {s_re, s_im}, 64'h0);

    // Test 1: single frame 1.0..8.0
    out_log.delete(); base = n_out;
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, fp[i], '0, i == 7, 1'b1, 1'b0);
      chk("t1_accept", s_inx, 1);
      chk("t1_no_early_valid", s_valid, 0);
    end
    tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    chk("t1_latency_valid", s_valid, 1);
    chk("t1_first_index", s_idx, 0);
    drain(base + 8, 20);
    check_log("t1_order");

    // Test 2: three frames back-to-back
    base = n_out; first_c = -1; last_c = -1;
    for (int i = 0; i < 24; i++) begin
      tick(1'b1, $urandom, $urandom, pos == 7, 1'b1, 1'b0);
      chk("t2_ready", s_inx, 1);
      if (s_outx) begin if (first_c < 0) first_c = cyc; last_c = cyc; end
    end
    b = 20;
    while (n_out < base + 24 && b > 0) begin
      tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      if (s_outx) begin if (first_c < 0) first_c = cyc; last_c = cyc; end
      b--;
    end
    chk("t2_count", n_out - base, 24);
    chk("t2_no_gaps", last_c - first_c, 23);

    // Test 3: downstream stalled, 20 offers
    acc0 = n_in; f_re = $urandom; f_im = $urandom;
    for (int i = 0; i < 20; i++) begin
      if (i == 0) tick(1'b1, f_re, f_im, 1'b0, 1'b0, 1'b0);
      else        tick(1'b1, $urandom, $urandom, pos == 7, 1'b0, 1'b0);
      if (i >= 16) chk("t3_ready_low", s_ready, 0);
    end
    chk("t3_accepted", n_in - acc0, 16);
    chk("t3_hold_valid", s_valid, 1);
    chk("t3_hold_slot0", {s_re, s_im}, {f_re, f_im});
    base = n_out; b = 40;
    while (n_out < base + 16 && b > 0) begin
      tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
      if (s_outx && n_out - base == 8) begin
        chk("t3_ready_at_8th", s_ready, 0);
        tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
        chk("t3_ready_after_8th", s_ready, 1);
      end
      b--;
    end
    chk("t3_count", n_out - base, 16);

    // Test 4: i_last at sample 5 and missing at sample 7
    errp0 = n_errp; out_log.delete(); base = n_out;
    send_fp_frame(5, 1'b0);
    drain(base + 8, 20);
    chk("t4_err_pulses", n_errp - errp0, 2);
    check_log("t4_order");

    // Test 5a: reset after 3 samples
    for (int i = 0; i < 3; i++) tick(1'b1, $urandom, $urandom, 1'b0, 1'b1, 1'b0);
    tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    chk("t5a_valid_low", s_valid, 0);
    out_log.delete(); base = n_out;
    send_fp_frame(7, 1'b1);
    drain(base + 8, 20);
    check_log("t5a_order");

    // Test 5b: reset mid-drain
    send_fp_frame(7, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b1);
    tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("t5b_valid_low", s_valid, 0);
    chk("t5b_index_zero", s_idx, 0);
    base = n_out;
    for (int i = 0; i < 8; i++) tick(1'b1, $urandom, $urandom, i == 7, 1'b0, 1'b0);
    tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    chk("t5b_new_index", s_idx, 0);
    drain(base + 8, 20);
    tick(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    chk("t5b_no_stale", s_valid, 0);

    // Test 6: random traffic, 50 frames, special FP patterns mixed in
    base = n_out; acc0 = n_in; b = 6000;
    while (n_out < base + 400 && b > 0) begin
      logic [31:0] r_re, r_im;
      logic v, r;
      case ($urandom_range(0, 7))
        0:       r_re = 32'h7FC00001;
        1:       r_re = 32'h00000001;
        2:       r_re = 32'hFF800000;
        default: r_re = $urandom;
      endcase
      r_im = ($urandom_range(0, 7) == 0) ? 32'h7FC00001 : $urandom;
      v = (n_in - acc0 < 400) && ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      tick(v, r_re, r_im, pos == 7, r, 1'b0);
      b--;
    end
    chk("t6_in_count", n_in - acc0, 400);
    chk("t6_out_count", n_out - base, 400);
    chk("t6_sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
